// File: rtl/sync_count_ctrl.sv
// -----------------------------------------------------------------------------
// sync_count_ctrl
//
// Start/stop controlled counter with a four-state run FSM (IDLE, RUN, HOLD,
// DONE). An accepted start captures the terminal limit and direction, loads
// the counter and begins counting. Counting freezes while pause is high and
// stops at the terminal value. done is then held until it is acknowledged.
// Every counter bit is built as a JK flip-flop with J=K=toggle. Loading and
// clearing the counter bypass the JK path.
//
// Configuration macro:
//   SYNC_COUNT_DOWN_EN  defined   : dir selects up (0) or down (1) counting
//                       undefined : up counting only; dir is ignored and the
//                                   down-toggle logic is not built
//
// Parameters:
//   WIDTH   counter width in bits (2..8)
//
// Ports:
//   clk     clock; all state changes happen on its rising edge
//   reset   synchronous active-low reset
//   start   run request, honoured only in IDLE
//   limit   terminal value, captured on an accepted start
//   dir     0 = up, 1 = down, captured on an accepted start
//   pause   freezes counting while high
//   ack     acknowledges done, honoured only in DONE
//   abort   cancels any run; next edge returns to IDLE with q = 0
//   q       counter value
//   busy    high in RUN and HOLD
//   tc      high in RUN/HOLD while q equals the terminal value
//   done    high in DONE
// -----------------------------------------------------------------------------
module sync_count_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic             dir,
    input  logic             pause,
    input  logic             ack,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;

    logic [WIDTH-1:0] terminal;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] jk_next;
    logic             at_term;
    logic             advance;
    logic             load_dir;

`ifdef SYNC_COUNT_DOWN_EN
    logic dir_q, dir_d;

    assign load_dir = dir;
    // Down runs stop at zero, up runs at the captured limit.
    assign terminal = dir_q ? '0 : limit_q;
`else
    logic unused_dir;

    assign unused_dir = dir;
    assign load_dir   = 1'b0;
    assign terminal   = limit_q;
`endif

    assign at_term = (count_q == terminal);
    assign advance = (state_q == S_RUN) && !pause && !at_term;

    // Ripple toggle enables. Bit i toggles when the counter advances and all
    // lower bits are 1 (up) or all lower bits are 0 (down).
    always_comb begin
        logic carry;
        carry  = advance;
        toggle = '0;
        for (int i = 0; i < WIDTH; i++) begin
            toggle[i] = carry;
`ifdef SYNC_COUNT_DOWN_EN
            carry = carry & (dir_q ? ~count_q[i] : count_q[i]);
`else
            carry = carry & count_q[i];
`endif
        end
    end

    // JK flip-flop next state with J = K = toggle: Q+ = J&~Q | ~K&Q.
    assign jk_next = (toggle & ~count_q) | (~toggle & count_q);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
`ifdef SYNC_COUNT_DOWN_EN
        dir_d   = dir_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    limit_d = limit;
`ifdef SYNC_COUNT_DOWN_EN
                    dir_d   = dir;
`endif
                    count_d = load_dir ? limit : '0;
                end
            end
            S_RUN: begin
                // Terminal count wins over pause.
                if (at_term) begin
                    state_d = S_DONE;
                end else if (pause) begin
                    state_d = S_HOLD;
                end else begin
                    count_d = jk_next;
                end
            end
            S_HOLD: begin
                // The edge that leaves HOLD does not advance the counter.
                if (!pause) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (ack) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase

        // Abort overrides start, pause and ack in every state.
        if (abort) begin
            state_d = S_IDLE;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so that every flop
        // samples the values from before the edge, independent of
        // statement order.
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            limit_q <= '0;
`ifdef SYNC_COUNT_DOWN_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
`ifdef SYNC_COUNT_DOWN_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign q    = count_q;
    assign busy = (state_q == S_RUN) || (state_q == S_HOLD);
    assign done = (state_q == S_DONE);
    assign tc   = busy && at_term;

endmodule

// File: tb/tb_sync_count_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sync_count_ctrl
//
// Self-checking bench for sync_count_ctrl (WIDTH = 4). Directed scenarios run
// first, followed by a randomized phase. Every output is compared after every
// edge with a behavioural model that counts with plain modulo arithmetic.
// Selected points are also compared with literal expected values.
// The bench follows SYNC_COUNT_DOWN_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_sync_count_ctrl;

    localparam int W   = 4;
    localparam int MOD = 1 << W;
`ifdef SYNC_COUNT_DOWN_EN
    localparam bit DOWN_EN = 1'b1;
`else
    localparam bit DOWN_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] limit;
    logic         dir;
    logic         pause;
    logic         ack;
    logic         abort;
    logic [W-1:0] q;
    logic         busy;
    logic         tc;
    logic         done;

    int checks = 0;
    int errors = 0;

    // Reference model state
    typedef enum int {M_IDLE, M_RUN, M_HOLD, M_DONE} mstate_t;
    mstate_t m_state = M_IDLE;
    int      m_q     = 0;
    int      m_limit = 0;
    bit      m_dir   = 1'b0;

    always #5 clk = ~clk;

    sync_count_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .limit (limit),
        .dir   (dir),
        .pause (pause),
        .ack   (ack),
        .abort (abort),
        .q     (q),
        .busy  (busy),
        .tc    (tc),
        .done  (done)
    );

    function automatic int m_term();
        return m_dir ? 0 : m_limit;
    endfunction

    function automatic bit m_busy();
        return (m_state == M_RUN) || (m_state == M_HOLD);
    endfunction

    // One rising edge of the reference model, using the current inputs.
    function automatic void model_edge();
        if (!reset) begin
            m_state = M_IDLE;
            m_q     = 0;
            m_limit = 0;
            m_dir   = 1'b0;
        end else if (abort) begin
            m_state = M_IDLE;
            m_q     = 0;
        end else begin
            case (m_state)
                M_IDLE: if (start) begin
                    m_limit = int'(limit);
                    m_dir   = DOWN_EN & dir;
                    m_q     = m_dir ? int'(limit) : 0;
                    m_state = M_RUN;
                end
                M_RUN: begin
                    if (m_q == m_term())  m_state = M_DONE;
                    else if (pause)       m_state = M_HOLD;
                    else if (m_dir)       m_q = (m_q + MOD - 1) % MOD;
                    else                  m_q = (m_q + 1) % MOD;
                end
                M_HOLD: if (!pause) m_state = M_RUN;
                M_DONE: if (ack) begin
                    m_state = M_IDLE;
                    m_q     = 0;
                end
                default: m_state = M_IDLE;
            endcase
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},    32'(q),    32'(m_q));
        check({tag, ".busy"}, 32'(busy), 32'(m_busy()));
        check({tag, ".tc"},   32'(tc),   32'(m_busy() && (m_q == m_term())));
        check({tag, ".done"}, 32'(done), 32'(m_state == M_DONE));
    endtask

    // Advance one edge, then compare all outputs 1 time unit later.
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Step until done or until the budget runs out. Returns the edges taken.
    task automatic run_to_done(input string tag, input int budget, output int edges);
        edges = 0;
        while (!done && edges < budget) begin
            step(tag);
            edges++;
        end
    endtask

    initial begin
        int edges;

        reset = 1'b0; start = 1'b0; limit = '0; dir = 1'b0;
        pause = 1'b0; ack = 1'b0; abort = 1'b0;

        // ---- reset state ----
        step("reset");
        step("reset2");
        check("reset.q_zero", 32'(q), 0);
        check("reset.busy_low", 32'(busy), 0);
        reset = 1'b1;
        step("idle");

        // ---- up run, limit 5: q = 0..5, tc at 5, done next edge ----
        limit = 4'd5; dir = 1'b0; start = 1'b1;
        step("up5.start");
        start = 1'b0;
        check("up5.q0", 32'(q), 0);
        for (int i = 1; i <= 5; i++) begin
            step("up5.run");
            check("up5.q", 32'(q), 32'(i));
        end
        check("up5.tc_at_5", 32'(tc), 1);
        step("up5.done");
        check("up5.done_high", 32'(done), 1);
        check("up5.busy_low", 32'(busy), 0);
        ack = 1'b1;
        step("up5.ack");
        ack = 1'b0;

        // ---- dir = 1, limit 3: down 3..0 with the macro, else up 0..3 ----
        limit = 4'd3; dir = 1'b1; start = 1'b1;
        step("dir3.start");
        start = 1'b0; dir = 1'b0;
        check("dir3.q_first", 32'(q), DOWN_EN ? 32'd3 : 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step("dir3.run");
            check("dir3.q", 32'(q), DOWN_EN ? 32'(3 - i) : 32'(i));
        end
        check("dir3.tc", 32'(tc), 1);
        step("dir3.done");
        check("dir3.done_high", 32'(done), 1);
        ack = 1'b1;
        step("dir3.ack");
        ack = 1'b0;

        // ---- up run, limit 9, pause high for 3 edges at q = 4 ----
        limit = 4'd9; start = 1'b1;
        step("pause.start");
        start = 1'b0;
        edges = 0;
        for (int i = 0; i < 4; i++) begin
            step("pause.run");
            edges++;
        end
        check("pause.q4", 32'(q), 4);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("pause.hold");
            edges++;
            check("pause.hold_q", 32'(q), 4);
            check("pause.hold_busy", 32'(busy), 1);
        end
        pause = 1'b0;
        step("pause.resume");
        edges++;
        check("pause.resume_q", 32'(q), 4);
        step("pause.q5");
        edges++;
        check("pause.q5", 32'(q), 5);
        begin
            int more;
            run_to_done("pause.tail", 40, more);
            edges += more;
        end
        // Unpaused latency is limit+1. Three HOLD cycles and the
        // non-advancing resume edge add four more edges.
        check("pause.latency", 32'(edges), 32'(9 + 1 + 3 + 1));
        ack = 1'b1;
        step("pause.ack");
        ack = 1'b0;

        // ---- abort at q = 6, limit 12; ack during run is ignored ----
        limit = 4'd12; start = 1'b1;
        step("abort.start");
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ack = (i == 2);
            step("abort.run");
        end
        ack = 1'b0;
        check("abort.q6", 32'(q), 6);
        abort = 1'b1;
        step("abort.edge");
        abort = 1'b0;
        check("abort.q_zero", 32'(q), 0);
        check("abort.busy_low", 32'(busy), 0);
        check("abort.no_done", 32'(done), 0);
        step("abort.idle");
        limit = 4'd2; start = 1'b1;
        step("abort.restart");
        start = 1'b0;
        check("abort.restart_busy", 32'(busy), 1);
        run_to_done("abort.rerun", 20, edges);
        check("abort.rerun_latency", 32'(edges), 3);
        ack = 1'b1;
        step("abort.ack");
        ack = 1'b0;

        // ---- limit 0: one RUN cycle with tc, done held until ack ----
        limit = 4'd0; start = 1'b1;
        step("zero.start");
        start = 1'b0;
        check("zero.q", 32'(q), 0);
        check("zero.tc", 32'(tc), 1);
        check("zero.busy", 32'(busy), 1);
        step("zero.done");
        check("zero.done_high", 32'(done), 1);
        start = 1'b1; limit = 4'd7;
        for (int i = 0; i < 3; i++) step("zero.wait");
        start = 1'b0;
        check("zero.done_held", 32'(done), 1);
        ack = 1'b1;
        step("zero.ack");
        ack = 1'b0;
        check("zero.ack_q", 32'(q), 0);
        check("zero.ack_done", 32'(done), 0);

        // ---- start while busy ignored, reset mid-run at q = 7 ----
        limit = 4'd10; start = 1'b1;
        step("rst.start");
        start = 1'b0;
        for (int i = 0; i < 3; i++) step("rst.run");
        limit = 4'd2; start = 1'b1;
        step("rst.busy_start");
        start = 1'b0;
        check("rst.start_ignored", 32'(q), 4);
        for (int i = 0; i < 3; i++) step("rst.run2");
        check("rst.q7", 32'(q), 7);
        reset = 1'b0;
        step("rst.edge");
        reset = 1'b1;
        check("rst.q", 32'(q), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.tc", 32'(tc), 0);
        check("rst.done", 32'(done), 0);
        step("rst.after");
        check("rst.no_done", 32'(done), 0);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) != 0);
            abort = ($urandom_range(0, 29) == 0);
            start = ($urandom_range(0, 2) == 0);
            pause = ($urandom_range(0, 3) == 0);
            ack   = ($urandom_range(0, 2) == 0);
            dir   = 1'($urandom_range(0, 1));
            limit = W'($urandom_range(0, MOD - 1));
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
